// File: rtl/pe_rr_arbiter_pkg.sv
// Shared definitions for the pe_rr_arbiter slice: FSM state and mode encodings
// plus a constant-foldable ceil(log2) helper used to size grant indices.
package pe_rr_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam logic PE_MODE_FIXED = 1'b0;
    localparam logic PE_MODE_RR    = 1'b1;

    // Index width for n lines; never below one bit so a 1-line build still has a port.
    function automatic int pe_clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return (r < 32'sd1) ? 32'sd1 : r;
    endfunction

endpackage

// File: rtl/pe_rr_arbiter_if.sv
// Request/grant bundle between the issue logic (master) and the arbiter (slave).
interface pe_rr_arbiter_if
    import pe_rr_arbiter_pkg::*;
#(
    parameter int N = 32
) ();

    localparam int IW = pe_clog2(N);

    logic [N-1:0]  req;
    logic          mode;
    logic          gnt_ready;
    logic          gnt_valid;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;

    modport master (
        output req,
        output mode,
        output gnt_ready,
        input  gnt_valid,
        input  gnt,
        input  gnt_idx
    );

    modport slave (
        input  req,
        input  mode,
        input  gnt_ready,
        output gnt_valid,
        output gnt,
        output gnt_idx
    );

endinterface

// File: rtl/pe_rr_arbiter_lsb_onehot.sv
// Combinational lowest-set-bit encoder: one-hot of the lowest set bit,
// an any-bit-set flag, and the binary index of that bit.
module pe_lsb_onehot
    import pe_rr_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]            vec_i,
    output logic [N-1:0]            onehot_o,
    output logic                    any_o,
    output logic [pe_clog2(N)-1:0]  idx_o
);

    localparam int            IW  = pe_clog2(N);
    localparam logic [N-1:0]  ONE = N'(1'b1);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        onehot_o = vec_i & (~vec_i + ONE);
        any_o    = |vec_i;
    end

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/pe_rr_arbiter.sv
// N-line arbiter with fixed-priority or round-robin selection and a registered
// valid/ready grant. Optional grant locking is enabled with PE_ARB_LOCK_EN.
module pe_rr_arbiter
    import pe_rr_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PE_ARB_LOCK_EN
    input  logic               lock,
`endif
    pe_rr_arbiter_if.slave     bus
);

    localparam int             IW       = pe_clog2(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1'b1);

    logic          state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          accept_s;
    logic          hold_s;
    logic [IW-1:0] adv_ptr_s;
    logic [IW-1:0] ptr_eff_s;
    logic [N-1:0]  mask_s;
    logic [N-1:0]  masked_req_s;

    logic [N-1:0]  m_oh_s, u_oh_s;
    logic          m_any_s, u_any_s;
    logic [IW-1:0] m_idx_s, u_idx_s;

    logic [N-1:0]  win_oh_s;
    logic [IW-1:0] win_idx_s;

    // Accept, lock-hold and pointer advance derived from the held grant.
    always_comb begin
        accept_s  = (state_q == ST_GRANT) && bus.gnt_ready;
        adv_ptr_s = (idx_q == LAST_IDX) ? '0 : (idx_q + IDX_ONE);
`ifdef PE_ARB_LOCK_EN
        hold_s    = lock && accept_s && bus.req[idx_q];
`else
        hold_s    = 1'b0;
`endif
    end

    // On an accept the new grant must already see the advanced pointer,
    // otherwise back-to-back round-robin grants would repeat the same index.
    always_comb begin
        if (accept_s && !hold_s) begin
            ptr_eff_s = adv_ptr_s;
        end else begin
            ptr_eff_s = ptr_q;
        end
    end

    // Thermometer mask keeping requesters at or above the pointer.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (i >= int'(ptr_eff_s));
        end
        masked_req_s = bus.req & mask_s;
    end

    pe_lsb_onehot #(.N(N)) u_masked_enc (
        .vec_i    (masked_req_s),
        .onehot_o (m_oh_s),
        .any_o    (m_any_s),
        .idx_o    (m_idx_s)
    );

    pe_lsb_onehot #(.N(N)) u_unmasked_enc (
        .vec_i    (bus.req),
        .onehot_o (u_oh_s),
        .any_o    (u_any_s),
        .idx_o    (u_idx_s)
    );

    // Winner select; round-robin falls back to the unmasked vector on wrap.
    always_comb begin
        win_oh_s  = u_oh_s;
        win_idx_s = u_idx_s;
        if (hold_s) begin
            win_oh_s  = gnt_q;
            win_idx_s = idx_q;
        end else if ((bus.mode == PE_MODE_RR) && m_any_s) begin
            win_oh_s  = m_oh_s;
            win_idx_s = m_idx_s;
        end else begin
            win_oh_s  = u_oh_s;
            win_idx_s = u_idx_s;
        end
    end

    // Next-state logic; the grant only reloads in IDLE or on an accept.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (u_any_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = win_oh_s;
                    idx_d   = win_idx_s;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_GRANT: begin
                if (bus.gnt_ready) begin
                    ptr_d = hold_s ? ptr_q : adv_ptr_s;
                    if (u_any_s) begin
                        state_d = ST_GRANT;
                        gnt_d   = win_oh_s;
                        idx_d   = win_idx_s;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt_valid = (state_q == ST_GRANT);
    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;

endmodule

// File: tb/tb_pe_rr_arbiter.sv
// Directed self-checking bench for pe_rr_arbiter (N=8 and N=32 instances).
module tb_pe_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
`ifdef PE_ARB_LOCK_EN
    logic lock8;
    logic lock32;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_rr_arbiter_if #(.N(8))  bus8  ();
    pe_rr_arbiter_if #(.N(32)) bus32 ();

    pe_rr_arbiter #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef PE_ARB_LOCK_EN
        .lock  (lock8),
`endif
        .bus   (bus8)
    );

    pe_rr_arbiter #(.N(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef PE_ARB_LOCK_EN
        .lock  (lock32),
`endif
        .bus   (bus32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus8.req        = 8'h00;
        bus8.mode       = 1'b0;
        bus8.gnt_ready  = 1'b0;
        bus32.req       = 32'h0;
        bus32.mode      = 1'b0;
        bus32.gnt_ready = 1'b0;
`ifdef PE_ARB_LOCK_EN
        lock8  = 1'b0;
        lock32 = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus8.req        = 8'hFF;
        bus8.mode       = 1'b1;
        bus8.gnt_ready  = 1'b1;
        bus32.req       = 32'hFFFF_FFFF;
        bus32.mode      = 1'b0;
        bus32.gnt_ready = 1'b0;
`ifdef PE_ARB_LOCK_EN
        lock8  = 1'b0;
        lock32 = 1'b0;
`endif
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL reset8: got v=%b gnt=%h idx=%0d want v=0 gnt=00 idx=0",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        n_checks++;
        if ({bus32.gnt_valid, bus32.gnt, bus32.gnt_idx} !== {1'b0, 32'h0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset32: got v=%b gnt=%h idx=%0d want v=0 gnt=0 idx=0",
                     bus32.gnt_valid, bus32.gnt, bus32.gnt_idx);
        end
        do_reset();
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL idle_no_req: got v=%b gnt=%h idx=%0d want v=0 gnt=00 idx=0",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        bus8.mode      = 1'b0;
        bus8.req       = 8'b1010_0100;
        bus8.gnt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h04, 3'd2}) begin
                n_fail++;
                $display("FAIL fixed[%0d]: got v=%b gnt=%h idx=%0d want v=1 gnt=04 idx=2",
                         k, bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
            end
        end
        // pointer kept tracking in fixed mode (now 3): switch to round-robin
        bus8.mode = 1'b1;
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h20, 3'd5}) begin
            n_fail++;
            $display("FAIL fixed_to_rr_a: got v=%b gnt=%h idx=%0d want v=1 gnt=20 idx=5",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h80, 3'd7}) begin
            n_fail++;
            $display("FAIL fixed_to_rr_b: got v=%b gnt=%h idx=%0d want v=1 gnt=80 idx=7",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h04, 3'd2}) begin
            n_fail++;
            $display("FAIL fixed_to_rr_c: got v=%b gnt=%h idx=%0d want v=1 gnt=04 idx=2",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
    endtask

    task automatic test_rr_all();
        logic [7:0] exp_gnt;
        logic [2:0] exp_idx;
        do_reset();
        bus8.mode      = 1'b1;
        bus8.req       = 8'hFF;
        bus8.gnt_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            exp_idx = 3'(k % 8);
            exp_gnt = 8'h01 << exp_idx;
            n_checks++;
            if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, exp_gnt, exp_idx}) begin
                n_fail++;
                $display("FAIL rr_all[%0d]: got v=%b gnt=%h idx=%0d want v=1 gnt=%h idx=%0d",
                         k, bus8.gnt_valid, bus8.gnt, bus8.gnt_idx, exp_gnt, exp_idx);
            end
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        bus8.mode      = 1'b1;
        bus8.req       = 8'h20;
        bus8.gnt_ready = 1'b0;
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h20, 3'd5}) begin
            n_fail++;
            $display("FAIL wrap_setup: got v=%b gnt=%h idx=%0d want v=1 gnt=20 idx=5",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        // accepting idx 5 moves ptr to 6; only bits 0/1 requesting
        bus8.req       = 8'b0000_0011;
        bus8.gnt_ready = 1'b1;
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL wrap_a: got v=%b gnt=%h idx=%0d want v=1 gnt=01 idx=0",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL wrap_b: got v=%b gnt=%h idx=%0d want v=1 gnt=02 idx=1",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL wrap_c: got v=%b gnt=%h idx=%0d want v=1 gnt=01 idx=0",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus32.mode      = 1'b0;
        bus32.req       = 32'h8000_0001;
        bus32.gnt_ready = 1'b0;
        step();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) bus32.req = 32'h0;
            if (c == 3) bus32.mode = 1'b1;
            n_checks++;
            if ({bus32.gnt_valid, bus32.gnt, bus32.gnt_idx} !== {1'b1, 32'h1, 5'd0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b gnt=%h idx=%0d want v=1 gnt=00000001 idx=0",
                         c, bus32.gnt_valid, bus32.gnt, bus32.gnt_idx);
            end
            step();
        end
        bus32.gnt_ready = 1'b1;
        step();
        n_checks++;
        if ({bus32.gnt_valid, bus32.gnt, bus32.gnt_idx} !== {1'b0, 32'h0, 5'd0}) begin
            n_fail++;
            $display("FAIL accept_empty: got v=%b gnt=%h idx=%0d want v=0 gnt=0 idx=0",
                     bus32.gnt_valid, bus32.gnt, bus32.gnt_idx);
        end
        step();
        n_checks++;
        if ({bus32.gnt_valid, bus32.gnt, bus32.gnt_idx} !== {1'b0, 32'h0, 5'd0}) begin
            n_fail++;
            $display("FAIL idle_stays: got v=%b gnt=%h idx=%0d want v=0 gnt=0 idx=0",
                     bus32.gnt_valid, bus32.gnt, bus32.gnt_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus8.mode      = 1'b1;
        bus8.req       = 8'h0F;
        bus8.gnt_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        bus8.gnt_ready = 1'b0;
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h08, 3'd3}) begin
            n_fail++;
            $display("FAIL pre_rst_hold: got v=%b gnt=%h idx=%0d want v=1 gnt=08 idx=3",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL async_drop: got v=%b gnt=%h idx=%0d want v=0 gnt=00 idx=0",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        bus8.req = 8'h0C;
        #2;
        rst_n = 1'b1;
        // ptr back at 0 selects idx 2; a stale ptr of 3 would pick idx 3
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h04, 3'd2}) begin
            n_fail++;
            $display("FAIL post_rst_ptr: got v=%b gnt=%h idx=%0d want v=1 gnt=04 idx=2",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
        bus8.req       = 8'h08;
        bus8.gnt_ready = 1'b1;
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h08, 3'd3}) begin
            n_fail++;
            $display("FAIL post_rst_idx3: got v=%b gnt=%h idx=%0d want v=1 gnt=08 idx=3",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
    endtask

`ifdef PE_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        bus8.mode      = 1'b1;
        bus8.req       = 8'hFF;
        bus8.gnt_ready = 1'b1;
        lock8          = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h01, 3'd0}) begin
                n_fail++;
                $display("FAIL lock[%0d]: got v=%b gnt=%h idx=%0d want v=1 gnt=01 idx=0",
                         k, bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
            end
        end
        lock8 = 1'b0;
        step();
        n_checks++;
        if ({bus8.gnt_valid, bus8.gnt, bus8.gnt_idx} !== {1'b1, 8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL unlock: got v=%b gnt=%h idx=%0d want v=1 gnt=02 idx=1",
                     bus8.gnt_valid, bus8.gnt, bus8.gnt_idx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_wrap();
        test_hold();
        test_async_reset();
`ifdef PE_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
